// File: rtl/sort_ctrl.sv
// Bubble-sort sequencer: an N x 32-bit register bank sorted in place through
// one shared unsigned comparator, one compare (plus optional swap) per cycle.

module compare #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt,
    output logic         lt
);
    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);
endmodule

module sort_ctrl #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             start,
    input  logic             order,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [31:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic [15:0]      swap_count
);
    typedef enum logic [1:0] {IDLE, CMP, SWAP, DONE} state_t;

    // Last pass index and the inner-loop bound base (N-2), sized to the counters.
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);
    localparam logic [IDX_W:0]   NM2       = (IDX_W + 1)'(N - 2);

    state_t                 state, nxt;
    logic [N-1:0][31:0]     mem;
    logic [IDX_W-1:0]       i, pass;
    logic                   swapped, ord;

    logic [IDX_W-1:0]       i1;
    logic [31:0]            a_w, b_w;
    logic                   c_eq, c_gt, c_lt;
    logic                   swap_cond, adv, eop, finish, swapped_eff;
    logic [IDX_W:0]         lim;

    assign i1  = i + IDX_W'(1);
    assign a_w = mem[i];
    assign b_w = mem[i1];

    compare #(.W(32)) u_cmp (
        .a  (a_w),
        .b  (b_w),
        .eq (c_eq),
        .gt (c_gt),
        .lt (c_lt)
    );

    // Equal words never move, which keeps the sort stable.
    assign swap_cond = !c_eq && (ord ? c_lt : c_gt);

    // Inner loop runs while i < N-2-pass; the swap happening this cycle counts
    // toward the pass's swapped flag.
    assign lim         = NM2 - {1'b0, pass};
    assign eop         = ({1'b0, i} >= lim);
    assign swapped_eff = swapped || (state == SWAP);
    assign finish      = eop && (!swapped_eff || (pass == LAST_PASS));

    assign rd_data = mem[rd_addr];
    assign busy    = (state == CMP) || (state == SWAP);
    assign done    = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state: CMP or SWAP advances the index/pass, ending in DONE.
    always_comb begin
        nxt = state;
        adv = 1'b0;
        case (state)
            IDLE:    if (start) nxt = CMP;
            CMP:     if (swap_cond) nxt = SWAP; else adv = 1'b1;
            SWAP:    adv = 1'b1;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (adv) nxt = finish ? DONE : CMP;
    end

    // Bank, loop counters, latched order and swap statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem        <= '0;
            i          <= '0;
            pass       <= '0;
            swapped    <= 1'b0;
            ord        <= 1'b0;
            swap_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) mem[wr_addr] <= wr_data;
                    if (start) begin
                        ord        <= order;
                        swap_count <= '0;
                        i          <= '0;
                        pass       <= '0;
                        swapped    <= 1'b0;
                    end
                end
                SWAP: begin
                    mem[i]  <= b_w;
                    mem[i1] <= a_w;
                    swapped <= 1'b1;
                    if (swap_count != 16'hFFFF) swap_count <= swap_count + 16'd1;
                end
                default: ;
            endcase
            // A new pass overrides the swapped flag set by a SWAP this cycle.
            if (adv) begin
                if (!eop) begin
                    i <= i1;
                end else if (!finish) begin
                    pass    <= pass + IDX_W'(1);
                    i       <= '0;
                    swapped <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sort_ctrl.sv
// Directed + randomized bench for sort_ctrl against a sorting/inversion model.

module tb_sort_ctrl;
    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [31:0]      wr_data;
    logic             start;
    logic             order;
    logic [IDX_W-1:0] rd_addr;
    logic [31:0]      rd_data;
    logic             busy;
    logic             done;
    logic [15:0]      swap_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] din   [N];
    logic [31:0] exp_s [N];
    int          exp_swaps;
    int          exp_busy;

    sort_ctrl #(.N(N), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .order      (order),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // x sits before y: does the pair violate the requested order?
    function automatic bit viol(input logic [31:0] x, input logic [31:0] y, input bit o);
        return o ? (x < y) : (x > y);
    endfunction

    // Expected result: sorted copy; swaps = inversion count; passes = (largest
    // per-element inversion count) + 1 confirming pass, capped at N-1.
    task automatic model(input bit o);
        logic [31:0] q[$];
        int kmax, k, passes;
        q = {};
        for (int j = 0; j < N; j++) q.push_back(din[j]);
        if (o) q.rsort(); else q.sort();
        for (int j = 0; j < N; j++) exp_s[j] = q[j];
        exp_swaps = 0;
        kmax = 0;
        for (int j = 0; j < N; j++) begin
            k = 0;
            for (int m = 0; m < j; m++) if (viol(din[m], din[j], o)) k++;
            exp_swaps += k;
            if (k > kmax) kmax = k;
        end
        passes = (kmax + 1 < N - 1) ? kmax + 1 : N - 1;
        exp_busy = exp_swaps;
        for (int p = 0; p < passes; p++) exp_busy += N - 1 - p;
    endtask

    task automatic load(input int nwords);
        for (int a = 0; a < nwords; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = IDX_W'(a); wr_data = din[a];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic readback(input string tag);
        for (int a = 0; a < N; a++) begin
            rd_addr = IDX_W'(a);
            #1;
            chk(tag, rd_data, exp_s[a]);
        end
    endtask

    // Start a sort (optionally writing the last word in the start cycle),
    // optionally disturbing it mid-way, and check timing, count and result.
    task automatic run_sort(input bit o, input bit disturb, input bit wa, input string tag);
        int  cyc;
        bit  seen;
        model(o);
        @(negedge clk);
        order = o; start = 1'b1;
        if (wa) begin wr_en = 1'b1; wr_addr = IDX_W'(N - 1); wr_data = din[N-1]; end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0; order = ~o;
        cyc = 0; seen = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) cyc++;
            if (disturb && t == 5) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEADBEEF;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " busy_cycles"}, 32'(cyc), 32'(exp_busy));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " swap_count"}, 32'(swap_count), 32'(exp_swaps));
        readback({tag, " data"});
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; order = 1'b0; rd_addr = '0;
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset swap_count", 32'(swap_count), 32'd0);
        chk("reset rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Already sorted ascending.
        for (int a = 0; a < N; a++) din[a] = 32'(a + 1);
        load(N);
        run_sort(1'b0, 1'b0, 1'b0, "sorted");

        // Fully reversed, then swap_count must hold while idle.
        for (int a = 0; a < N; a++) din[a] = 32'(N - a);
        load(N);
        run_sort(1'b0, 1'b0, 1'b0, "reverse");
        repeat (3) @(negedge clk);
        chk("swap_count_hold", 32'(swap_count), 32'd28);

        // Descending with unsigned extremes and duplicates.
        din = '{32'h0, 32'hFFFFFFFF, 32'd5, 32'd5, 32'h80000000, 32'd1, 32'd2, 32'd3};
        load(N);
        run_sort(1'b1, 1'b0, 1'b0, "desc_unsigned");

        // start/write while busy must be ignored.
        for (int a = 0; a < N; a++) din[a] = 32'(N - a);
        load(N);
        run_sort(1'b0, 1'b1, 1'b0, "ignored_inputs");

        // Asynchronous reset in the middle of a clock phase.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst busy", 32'(busy), 32'd0);
        chk("async_rst done", 32'(done), 32'd0);
        chk("async_rst swap_count", 32'(swap_count), 32'd0);
        for (int a = 0; a < N; a++) begin
            rd_addr = IDX_W'(a); #1;
            chk("async_rst bank", rd_data, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Reset 10 cycles into a sort, then a clean sort afterwards.
        for (int a = 0; a < N; a++) din[a] = 32'(N - a);
        load(N);
        @(negedge clk);
        order = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midsort_rst busy", 32'(busy), 32'd0);
        chk("midsort_rst swap_count", 32'(swap_count), 32'd0);
        for (int a = 0; a < N; a++) begin
            rd_addr = IDX_W'(a); #1;
            chk("midsort_rst bank", rd_data, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < N; a++) din[a] = $urandom;
        load(N);
        run_sort(1'b1, 1'b0, 1'b0, "after_rst");

        // Randomized trials; odd trials write the last word in the start cycle.
        for (int tr = 0; tr < 12; tr++) begin
            for (int a = 0; a < N; a++)
                din[a] = (tr % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            load((tr % 2 == 1) ? N - 1 : N);
            run_sort(1'($urandom_range(0, 1)), 1'b0, 1'(tr % 2), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
- Sequencer for one shared 32-bit unsigned `compare` instance: eq/gt/lt.
- Holds an N-entry, 32-bit register bank and bubble-sorts it in place, one comparison per cycle, ascending or descending.
- Host loads words through a write port, pulses start, waits for done, then reads results back.
- Serves as the sort/rank engine beside the comparator in the lab datapath.

Parameters:
- N, 8, number of 32-bit entries (2..16).
- IDX_W, 3, address width; must equal ceil(log2(N)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe for the bank.
- wr_addr  input  IDX_W  write index.
- wr_data  input  32  write data.
- start  input  1  begin sort; sampled in IDLE only.
- order  input  1  0 = ascending, 1 = descending; latched at start.
- rd_addr  input  IDX_W  read index.
- rd_data  output  32  combinational mem[rd_addr]; valid in any state.
- busy  output  1  high in CMP and SWAP.
- done  output  1  one-cycle pulse when the sort completes.
- swap_count  output  16  swaps performed in the last or current sort; saturates at 0xFFFF.

Behaviour:
- Reset (async, any state):
  - state=IDLE; all mem entries=0.
  - busy=0, done=0, swap_count=0.
  - Pass/index counters, swapped flag and latched order cleared.
  - Reset mid-sort abandons the sort and clears the bank.
- Comparison:
  - Exactly one `compare` instance: A=mem[i], B=mem[i+1].
  - Comparison is unsigned 32-bit.
  - Swap condition: ascending and gt, or descending and lt.
  - eq never swaps, so the sort is stable.
- States:
  - IDLE:
    - wr_en writes mem[wr_addr]=wr_data.
    - start=1: latch order, clear swap_count, i=0, pass=0, swapped=0; next state CMP.
    - wr_en and start in the same cycle: the write lands, and the sort includes that word.
  - CMP (1 cycle):
    - Evaluate the swap condition.
    - If true: next state SWAP.
    - Else: advance.
  - SWAP (1 cycle):
    - Exchange mem[i] and mem[i+1].
    - Set swapped=1; swap_count += 1 (saturating).
    - Advance.
  - Advance:
    - If i < N-2-pass: i += 1, go to CMP.
    - Otherwise, at end of pass:
      - If swapped==0 or pass==N-2: go to DONE.
      - Else: pass += 1, i=0, swapped=0, go to CMP.
  - DONE (1 cycle): done=1, busy=0; next state IDLE.
- Timing:
  - busy rises the cycle after start is sampled.
  - Sort duration = compares + swaps cycles, then a 1-cycle DONE.
- Ignored inputs:
  - start while busy or in DONE is ignored.
  - wr_en while busy or in DONE is ignored; the bank is not corrupted.
- Hold and readback:
  - order changes mid-sort have no effect.
  - swap_count holds its value after done until the next start.
  - rd_data during a sort shows intermediate contents.

Test Plan:
- Reset check: assert rst mid-cycle -> busy=0, done=0, swap_count=0, and rd_data=0 for every address, all immediately (asynchronous).
- Already sorted: load 1..8, start, order=0 -> busy high exactly 7 cycles, done pulse 1 cycle, swap_count=0, contents unchanged.
- Reverse order: load 8,7,...,1, start, order=0 -> busy 56 cycles (28 compares + 28 swaps), swap_count=28, readback 1..8.
- Descending and unsigned: load {0, 0xFFFFFFFF, 5, 5, 0x80000000, 1, 2, 3}, order=1 -> readback 0xFFFFFFFF, 0x80000000, 5, 5, 3, 2, 1, 0.
- Ignored inputs while busy: during a reverse-order sort, pulse start and write 0xDEADBEEF to addr 0 -> neither has any effect; result and swap_count=28 match the undisturbed run.
- Reset mid-sort: assert rst 10 cycles into a sort -> IDLE with a cleared bank. A following load/start sorts correctly.
